// File: rtl/fetch_stall_responder_pkg.sv
// Shared fetch-stage constants: NOP encoding, PC step and default reset vector.
package fetch_stall_responder_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_stall_responder_if.sv
// Bus between the ID-stage hazard/branch logic, instruction memory and the fetch responder.
interface fetch_stall_responder_if #(
  parameter int CNT_W = 16
);

  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_flush;
  logic             branch_taken;
  logic [31:0]      branch_target;
  logic             jump;
  logic [31:0]      jump_target;
  logic [31:0]      imem_instr;
  logic             clr_counters;
  logic [31:0]      pc;
  logic [31:0]      if_id_pc_plus4;
  logic [31:0]      if_id_instr;
  logic             if_id_valid;
  logic             id_ex_bubble;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  logic             stall_timeout;
  logic             protocol_err;

  modport master (
    output pc_write, if_id_write, id_ex_flush, branch_taken, branch_target,
           jump, jump_target, imem_instr, clr_counters,
    input  pc, if_id_pc_plus4, if_id_instr, if_id_valid, id_ex_bubble,
           stall_cycles, flush_count, stall_timeout, protocol_err
  );

  modport slave (
    input  pc_write, if_id_write, id_ex_flush, branch_taken, branch_target,
           jump, jump_target, imem_instr, clr_counters,
    output pc, if_id_pc_plus4, if_id_instr, if_id_valid, id_ex_bubble,
           stall_cycles, flush_count, stall_timeout, protocol_err
  );

endinterface

// File: rtl/fetch_stall_responder_sat_counter.sv
// Saturating up-counter with synchronous clear that wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_stall_responder.sv
// Fetch-side owner of the PC and IF/ID register; applies stall, redirect and flush
// decisions from ID and keeps stall/flush statistics with sticky debug flags.
module fetch_stall_responder
  import fetch_stall_responder_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          CNT_W     = 16,
  parameter int          MAX_STALL = 8
) (
  input logic                    clk,
  input logic                    rst,
  fetch_stall_responder_if.slave bus
);

  localparam int             RUN_W    = $clog2(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_STALL - 1);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ifid_pc4_q, ifid_pc4_d;
  logic [31:0]      ifid_instr_q, ifid_instr_d;
  logic             ifid_valid_q, ifid_valid_d;
  logic             bubble_q;
  logic [RUN_W-1:0] run_q, run_d;
  logic             timeout_q, timeout_d;
  logic             perr_q, perr_d;
  logic             redirect_s;
  logic             flush_s;
  logic [31:0]      pc_plus4_s;

  // A redirect during a stall is dropped: the branch stays in IF/ID and resolves again.
  always_comb begin
    redirect_s   = (bus.branch_taken | bus.jump) & bus.pc_write;
    flush_s      = bus.if_id_write & redirect_s;
    pc_plus4_s   = pc_q + PC_INC;
    pc_d         = pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    run_d        = run_q;
    timeout_d    = timeout_q;
    perr_d       = perr_q;

    if (!bus.pc_write)         pc_d = pc_q;
    else if (bus.branch_taken) pc_d = bus.branch_target;
    else if (bus.jump)         pc_d = bus.jump_target;
    else                       pc_d = pc_plus4_s;

    if (!bus.if_id_write) begin
      ifid_pc4_d   = ifid_pc4_q;
      ifid_instr_d = ifid_instr_q;
      ifid_valid_d = ifid_valid_q;
    end else if (redirect_s) begin
      ifid_pc4_d   = 32'h0000_0000;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else begin
      ifid_pc4_d   = pc_plus4_s;
      ifid_instr_d = bus.imem_instr;
      ifid_valid_d = 1'b1;
    end

    // Run length saturates at the trigger value; the sticky flag keeps the history.
    if (bus.clr_counters) begin
      run_d     = '0;
      timeout_d = 1'b0;
      perr_d    = 1'b0;
    end else begin
      if (bus.pc_write)          run_d = '0;
      else if (run_q != RUN_LAST) run_d = run_q + {{(RUN_W-1){1'b0}}, 1'b1};
      else                       run_d = run_q;
      timeout_d = timeout_q | (~bus.pc_write & (run_q == RUN_LAST));
      perr_d    = perr_q | (bus.pc_write ^ bus.if_id_write);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      ifid_pc4_q   <= 32'h0000_0000;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      bubble_q     <= 1'b0;
      run_q        <= '0;
      timeout_q    <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      bubble_q     <= bus.id_ex_flush;
      run_q        <= run_d;
      timeout_q    <= timeout_d;
      perr_q       <= perr_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (bus.clr_counters),
    .inc_i   (~bus.pc_write),
    .count_o (bus.stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (bus.clr_counters),
    .inc_i   (flush_s),
    .count_o (bus.flush_count)
  );

  assign bus.pc             = pc_q;
  assign bus.if_id_pc_plus4 = ifid_pc4_q;
  assign bus.if_id_instr    = ifid_instr_q;
  assign bus.if_id_valid    = ifid_valid_q;
  assign bus.id_ex_bubble   = bubble_q;
  assign bus.stall_timeout  = timeout_q;
  assign bus.protocol_err   = perr_q;

endmodule

// File: tb/tb_fetch_stall_responder.sv
// Directed and randomized bench for fetch_stall_responder against a cycle-level reference model.
module tb_fetch_stall_responder;

  localparam int CNT_W     = 4;
  localparam int MAX_STALL = 8;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  fetch_stall_responder_if #(.CNT_W(CNT_W)) bus ();

  fetch_stall_responder #(
    .RESET_PC  (32'h0000_0000),
    .CNT_W     (CNT_W),
    .MAX_STALL (MAX_STALL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state: plain integers and flags
  logic [31:0] m_pc, m_pc4, m_instr;
  logic        m_valid, m_bub, m_to, m_perr;
  int          m_stall, m_flush, m_run;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0; m_bub = 1'b0;
    m_to = 1'b0; m_perr = 1'b0; m_stall = 0; m_flush = 0; m_run = 0;
  endtask

  task automatic check_all();
    chk("pc",      bus.pc,             m_pc);
    chk("pc4",     bus.if_id_pc_plus4, m_pc4);
    chk("instr",   bus.if_id_instr,    m_instr);
    chk("valid",   {31'd0, bus.if_id_valid},   {31'd0, m_valid});
    chk("bubble",  {31'd0, bus.id_ex_bubble},  {31'd0, m_bub});
    chk("stalls",  {28'd0, bus.stall_cycles},  32'(m_stall));
    chk("flushes", {28'd0, bus.flush_count},   32'(m_flush));
    chk("timeout", {31'd0, bus.stall_timeout}, {31'd0, m_to});
    chk("perr",    {31'd0, bus.protocol_err},  {31'd0, m_perr});
  endtask

  task automatic drive(input logic pw, input logic ifw, input logic bt, input logic [31:0] btgt,
                       input logic jp, input logic [31:0] jtgt, input logic [31:0] instr,
                       input logic flush, input logic clr);
    bus.pc_write = pw; bus.if_id_write = ifw; bus.branch_taken = bt; bus.branch_target = btgt;
    bus.jump = jp; bus.jump_target = jtgt; bus.imem_instr = instr;
    bus.id_ex_flush = flush; bus.clr_counters = clr;
  endtask

  // One clock: predict from the spec rules, advance, then compare everything.
  task automatic step();
    logic [31:0] n_pc, n_pc4, n_instr;
    logic        n_valid, redir;
    redir = (bus.branch_taken || bus.jump) && bus.pc_write;
    if (!bus.pc_write)         n_pc = m_pc;
    else if (bus.branch_taken) n_pc = bus.branch_target;
    else if (bus.jump)         n_pc = bus.jump_target;
    else                       n_pc = m_pc + 32'd4;
    if (!bus.if_id_write) begin
      n_pc4 = m_pc4; n_instr = m_instr; n_valid = m_valid;
    end else if (redir) begin
      n_pc4 = 32'h0; n_instr = 32'h0; n_valid = 1'b0;
    end else begin
      n_pc4 = m_pc + 32'd4; n_instr = bus.imem_instr; n_valid = 1'b1;
    end
    if (bus.clr_counters) begin
      m_stall = 0; m_flush = 0; m_run = 0; m_to = 1'b0; m_perr = 1'b0;
    end else begin
      if (!bus.pc_write && m_stall < CNT_MAX) m_stall++;
      if (bus.if_id_write && redir && m_flush < CNT_MAX) m_flush++;
      m_run = bus.pc_write ? 0 : m_run + 1;
      if (m_run >= MAX_STALL) m_to = 1'b1;
      if (bus.pc_write != bus.if_id_write) m_perr = 1'b1;
    end
    m_bub = bus.id_ex_flush;
    @(posedge clk);
    #1;
    m_pc = n_pc; m_pc4 = n_pc4; m_instr = n_instr; m_valid = n_valid;
    check_all();
  endtask

  task automatic run_cycles(input int n, input logic pw, input logic ifw);
    for (int i = 0; i < n; i++) begin
      drive(pw, ifw, 1'b0, 32'h0, 1'b0, 32'h0, $urandom(), 1'b0, 1'b0);
      step();
    end
  endtask

  initial begin
    model_reset();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h2008_0005, 1'b0, 1'b0);
    #12;
    check_all();
    rst = 1'b0;

    // First fetch after reset
    step();
    chk("first_pc", bus.pc, 32'h4);
    chk("first_instr", bus.if_id_instr, 32'h2008_0005);
    chk("first_pc4", bus.if_id_pc_plus4, 32'h4);
    run_cycles(3, 1'b1, 1'b1);
    chk("pc_0x10", bus.pc, 32'h10);

    // Three-cycle stall
    run_cycles(3, 1'b0, 1'b0);
    chk("stall_pc", bus.pc, 32'h10);
    chk("stall_cnt3", {28'd0, bus.stall_cycles}, 32'd3);
    chk("no_timeout", {31'd0, bus.stall_timeout}, 32'd0);
    run_cycles(2, 1'b1, 1'b1);

    // Taken branch at 0x18 flushes IF/ID
    drive(1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b0);
    step();
    chk("br_pc", bus.pc, 32'h40);
    chk("br_valid", {31'd0, bus.if_id_valid}, 32'd0);
    chk("br_flush1", {28'd0, bus.flush_count}, 32'd1);

    // Branch under stall is ignored, then taken on release
    drive(1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 32'h1111_1111, 1'b0, 1'b0);
    step();
    chk("stallbr_pc", bus.pc, 32'h40);
    chk("stallbr_flush", {28'd0, bus.flush_count}, 32'd1);
    drive(1'b1, 1'b1, 1'b1, 32'h80, 1'b1, 32'h300, 32'h1111_1111, 1'b0, 1'b0);
    step();
    chk("branch_over_jump", bus.pc, 32'h80);

    // Jump to the top of the address space, then PC wraps
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0);
    step();
    run_cycles(1, 1'b1, 1'b1);
    chk("wrap_pc", bus.pc, 32'h0);

    // Timeout on the 8th consecutive stall, then clear
    run_cycles(7, 1'b0, 1'b0);
    chk("to_at7", {31'd0, bus.stall_timeout}, 32'd0);
    run_cycles(1, 1'b0, 1'b0);
    chk("to_at8", {31'd0, bus.stall_timeout}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step();
    chk("clr_stalls", {28'd0, bus.stall_cycles}, 32'd0);
    chk("clr_to", {31'd0, bus.stall_timeout}, 32'd0);

    // Protocol error is sticky
    run_cycles(1, 1'b1, 1'b0);
    chk("perr_set", {31'd0, bus.protocol_err}, 32'd1);
    run_cycles(2, 1'b1, 1'b1);
    chk("perr_sticky", {31'd0, bus.protocol_err}, 32'd1);

    // Stall counter saturation
    run_cycles(20, 1'b0, 1'b0);
    chk("stall_sat", {28'd0, bus.stall_cycles}, CNT_MAX);

    // Asynchronous reset mid-stall with a pending branch
    drive(1'b0, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk("post_rst_pc", bus.pc, 32'h4);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic pw;
      pw = ($urandom_range(0, 3) != 0);
      drive(pw, ($urandom_range(0, 15) == 0) ? ~pw : pw,
            ($urandom_range(0, 5) == 0), $urandom() & 32'hFFFF_FFFC,
            ($urandom_range(0, 5) == 0), $urandom() & 32'hFFFF_FFFC,
            $urandom(), 1'($urandom_range(0, 1)), ($urandom_range(0, 60) == 0));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
